// File: rtl/imem_prefetch_buffer.sv
// imem_prefetch_buffer: instruction-fetch front end that prefetches sequential
// words from a req/gnt/rvalid memory into a small tagged FIFO and hands the
// core the word for the address it presented in the previous cycle.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | first cycle after reset, latch start address from the core
//   STREAM | issue sequential requests, fill FIFO, serve hits, detect misses
//   DRAIN  | wait out stale in-flight responses after a redirect
module imem_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_WORD        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr,
  output logic [31:0] instruction,
  output logic        inst_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [29:0]   fetch_addr_q, fetch_addr_d;
  logic [29:0]   lookup_q;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;

  logic [29:0]   fifo_tag_q  [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [29:0] head_tag, oldest_tag, exp_tag;
  logic [31:0] head_data;
  logic        fifo_empty, in_stream, miss, hit, rsp, room, granted;
  logic        push, pop, flush;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^inst_addr[1:0];

  // Head of FIFO, tag of the oldest in-flight request and hit/miss decode
  always_comb begin
    head_tag   = fifo_tag_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    oldest_tag = fetch_addr_q - 30'(outst_q);
    exp_tag    = fifo_empty ? oldest_tag : head_tag;
    in_stream  = (state_q == S_STREAM);
    miss       = in_stream && (lookup_q != exp_tag);
    hit        = in_stream && !fifo_empty && (head_tag == lookup_q);
    // A response with nothing outstanding is a leftover from before reset.
    rsp        = imem_rvalid && (outst_q != '0);
    // Outstanding requests already own a FIFO slot, so a push never blocks.
    room       = ((32'(count_q) + 32'(outst_q)) < DEPTH) &&
                 (32'(outst_q) < MAX_OUTSTANDING);
    imem_req   = in_stream && !miss && room;
    granted    = imem_req && imem_gnt;
    pop        = hit && (inst_addr[31:2] != lookup_q);
    push       = in_stream && !miss && rsp;
    flush      = miss;
  end

  assign imem_addr   = {fetch_addr_q, 2'b00};
  assign inst_ready  = hit;
  assign instruction = hit ? head_data : NOP_WORD;

  // Fetch sequencing, outstanding accounting and redirect handling
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    outst_d      = outst_q;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        fetch_addr_d = inst_addr[31:2];
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        outst_d = outst_q + OW'(granted) - OW'(rsp);
        if (granted) fetch_addr_d = fetch_addr_q + 30'd1;
        if (miss) begin
          fetch_addr_d = lookup_q;
          if (outst_d != '0) begin
            drop_cnt_d = outst_d;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Keep tracking the core so a second redirect while draining is honoured.
        fetch_addr_d = lookup_q;
        if (rsp) begin
          outst_d    = outst_q - OW'(1);
          drop_cnt_d = drop_cnt_q - OW'(1);
        end
        if (drop_cnt_d == '0) state_d = S_STREAM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      lookup_q     <= '0;
      outst_q      <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      lookup_q     <= inst_addr[31:2];
      outst_q      <= outst_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Tagged FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_tag_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_tag_q[wr_ptr_q]  <= oldest_tag;
        fifo_data_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Bench for imem_prefetch_buffer: directed cycle table, reset during drain,
// then a core/memory scoreboard run (deterministic, then randomized).
module tb_imem_prefetch_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] instruction;
  logic        inst_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  imem_prefetch_buffer #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .NOP_WORD(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr),
    .instruction(instruction), .inst_ready(inst_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected in it.
  typedef struct {
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] iaddr;
    logic        rdy;
    logic [31:0] instr;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(input logic [31:0] addr, input logic gnt, input logic rv,
                              input logic [31:0] rd_addr, input logic req,
                              input logic [31:0] iaddr, input logic rdy,
                              input logic [31:0] w_addr);
    vec_t v;
    v.addr  = addr;
    v.gnt   = gnt;
    v.rv    = rv;
    v.rdata = rv ? word_of(rd_addr) : 32'h0;
    v.req   = req;
    v.iaddr = iaddr;
    v.rdy   = rdy;
    v.instr = rdy ? word_of(w_addr) : NOP;
    return v;
  endfunction

  // Scoreboard state: core model, memory model, in-flight tracking.
  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  logic [31:0] exp_q[$];
  pend_t       pend_q[$];
  int          out_cnt, cyc, rdy_seen, first_rdy, last_rdy, idle_run;
  bit          rand_mode, stale_en;
  logic [31:0] core_pc, next_grant;

  function automatic logic [31:0] rand_target();
    return 32'h0000_8000 + ($urandom_range(0, 1023) << 2);
  endfunction

  // One scoreboard cycle, called at the falling edge.
  task automatic sb_cycle();
    pend_t p;
    bit    g;
    bit    stall;
    int    lat;
    total++;
    if (out_cnt > 2 || out_cnt < 0) begin
      bad++;
      $display("FAIL outstanding_limit: got %0d allowed 0..2", out_cnt);
    end
    if (inst_ready) begin
      idle_run = 0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_ready: got word %08h expected none", instruction);
      end else begin
        check("stream_word", instruction, exp_q[0]);
      end
      if (rdy_seen == 0) first_rdy = cyc;
      rdy_seen++;
      last_rdy = cyc;
      stall = rand_mode && ($urandom_range(0, 99) < 20);
      if (!stall) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (rand_mode && ($urandom_range(0, 99) < 10)) core_pc = rand_target();
        else core_pc = core_pc + 32'd4;
        exp_q.push_back(word_of(core_pc));
      end
    end else begin
      idle_run++;
      check("nop_when_not_ready", instruction, NOP);
      if (rand_mode && ($urandom_range(0, 99) < 3)) begin
        core_pc = rand_target();
        exp_q.delete();
        exp_q.push_back(word_of(core_pc));
      end
    end
    inst_addr = core_pc;

    if (imem_req) check("req_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
    if (stale_en && cyc < 2) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(p.a);
      out_cnt--;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    g = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_gnt = g;
    if (imem_req && g) begin
      lat   = rand_mode ? $urandom_range(1, 3) : 1;
      p.a   = imem_addr;
      p.due = cyc + lat;
      if (pend_q.size() != 0 && p.due <= pend_q[$].due) p.due = pend_q[$].due + 1;
      pend_q.push_back(p);
      out_cnt++;
      if (!rand_mode) begin
        check("grant_addr", imem_addr, next_grant);
        next_grant = next_grant + 32'd4;
      end
    end
  endtask

  initial begin
    int base_rdy;
    vt[0]  = mk(32'h1000, 1, 0, 0,        0, 32'h0000, 0, 0);
    vt[1]  = mk(32'h1000, 1, 0, 0,        1, 32'h1000, 0, 0);
    vt[2]  = mk(32'h1000, 1, 1, 32'h1000, 1, 32'h1004, 0, 0);
    vt[3]  = mk(32'h1000, 1, 1, 32'h1004, 1, 32'h1008, 1, 32'h1000);
    vt[4]  = mk(32'h1004, 1, 1, 32'h1008, 1, 32'h100C, 1, 32'h1000);
    vt[5]  = mk(32'h1004, 1, 1, 32'h100C, 1, 32'h1010, 1, 32'h1004);
    vt[6]  = mk(32'h1004, 1, 1, 32'h1010, 0, 32'h1014, 1, 32'h1004);
    vt[7]  = mk(32'h1004, 1, 0, 0,        0, 32'h1014, 1, 32'h1004);
    vt[8]  = mk(32'h1008, 1, 0, 0,        0, 32'h1014, 1, 32'h1004);
    vt[9]  = mk(32'h2000, 0, 0, 0,        1, 32'h1014, 1, 32'h1008);
    vt[10] = mk(32'h2000, 1, 0, 0,        0, 32'h1014, 0, 0);
    vt[11] = mk(32'h2000, 1, 0, 0,        1, 32'h2000, 0, 0);
    vt[12] = mk(32'h2000, 1, 0, 0,        1, 32'h2004, 0, 0);
    vt[13] = mk(32'h3000, 1, 0, 0,        0, 32'h2008, 0, 0);
    vt[14] = mk(32'h3000, 1, 1, 32'h2000, 0, 32'h2008, 0, 0);
    vt[15] = mk(32'h3000, 1, 0, 0,        0, 32'h3000, 0, 0);
    vt[16] = mk(32'h3000, 1, 1, 32'h2004, 0, 32'h3000, 0, 0);
    vt[17] = mk(32'h3000, 1, 0, 0,        1, 32'h3000, 0, 0);
    vt[18] = mk(32'h3000, 1, 1, 32'h3000, 1, 32'h3004, 0, 0);
    vt[19] = mk(32'h3004, 0, 0, 0,        1, 32'h3008, 1, 32'h3000);
    vt[20] = mk(32'h3004, 0, 1, 32'h3004, 1, 32'h3008, 0, 0);
    vt[21] = mk(32'h3004, 0, 0, 0,        1, 32'h3008, 1, 32'h3004);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req", {31'd0, imem_req}, 32'd0);
    check("reset_addr", imem_addr, 32'd0);
    check("reset_ready", {31'd0, inst_ready}, 32'd0);
    check("reset_instr", instruction, NOP);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      inst_addr   = vt[i].addr;
      imem_gnt    = vt[i].gnt;
      imem_rvalid = vt[i].rv;
      imem_rdata  = vt[i].rdata;
      #1;
      check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].iaddr);
      check($sformatf("vec%0d_ready", i), {31'd0, inst_ready}, {31'd0, vt[i].rdy});
      check($sformatf("vec%0d_instr", i), instruction, vt[i].instr);
      @(negedge clk);
    end

    // Build up two outstanding requests, redirect, then reset inside DRAIN.
    inst_addr = 32'h3004; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    #1;
    check("pre_a_ready", {31'd0, inst_ready}, 32'd1);
    check("pre_a_instr", instruction, word_of(32'h3004));
    check("pre_a_addr", imem_addr, 32'h3008);
    @(negedge clk);
    #1;
    check("pre_b_req", {31'd0, imem_req}, 32'd1);
    check("pre_b_addr", imem_addr, 32'h300C);
    @(negedge clk);
    inst_addr = 32'h4000;
    #1;
    check("pre_c_req_at_max", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check("miss_ready", {31'd0, inst_ready}, 32'd0);
    check("miss_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check("drain_req", {31'd0, imem_req}, 32'd0);
    check("drain_addr", imem_addr, 32'h4000);
    check("drain_ready", {31'd0, inst_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_ready", {31'd0, inst_ready}, 32'd0);
    check("midrst_instr", instruction, NOP);
    check("midrst_addr", imem_addr, 32'd0);
    repeat (2) @(negedge clk);

    // Cold start after reset with stale responses arriving in the first cycles.
    rst_n = 1'b1;
    cyc = 0; rdy_seen = 0; first_rdy = -1; last_rdy = -1; idle_run = 0;
    out_cnt = 0; rand_mode = 1'b0; stale_en = 1'b1;
    core_pc = 32'h1000; inst_addr = core_pc; next_grant = 32'h1000;
    exp_q.delete(); pend_q.delete();
    exp_q.push_back(word_of(core_pc));
    while (rdy_seen < 17 && cyc < 60) begin
      sb_cycle();
      @(negedge clk);
      cyc++;
    end
    stale_en = 1'b0;
    check("cold_first_ready_cycle", 32'(first_rdy), 32'd3);
    check("stream_last_ready_cycle", 32'(last_rdy), 32'd19);

    // Randomized grants, latencies, stalls and redirects.
    rand_mode = 1'b1;
    base_rdy  = rdy_seen;
    for (int k = 0; k < 800; k++) begin
      sb_cycle();
      if (idle_run > 40) begin
        total++; bad++;
        $display("FAIL ready_timeout: got %0d idle cycles allowed 40", idle_run);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (rdy_seen - base_rdy < 100) begin
      bad++;
      $display("FAIL random_throughput: got %0d words expected at least 100", rdy_seen - base_rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got time %0t limit 100000", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/imem_prefetch_buffer.md
Name: imem_prefetch_buffer

Overview:
- Instruction-fetch front end between the RV32E core's fetch port (inst_addr / instruction / inst_ready) and a pipelined instruction memory with a req/gnt/rvalid handshake.
- Prefetches sequential words into a small tagged FIFO.
- Each cycle, returns the word for the address the core presented in the previous cycle. This preserves the core's synchronous-SRAM fetch timing.
- On a tag miss (taken branch, jump, reset start), flushes the FIFO, discards in-flight responses and restarts fetch at the requested address.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2); each entry holds {addr[31:2], data[31:0]}
MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests (>=1, <=DEPTH)
NOP_WORD, 32'h0000_0013, value driven on instruction when inst_ready=0

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
inst_addr  input  32  core next-fetch address (the core's pc_next); bits [1:0] ignored
instruction  output  32  word for the address registered last cycle; NOP_WORD when not ready
inst_ready  output  1  instruction is valid for the previously presented inst_addr
imem_req  output  1  memory request
imem_addr  output  32  request address, word aligned ([1:0]=0)
imem_gnt  input  1  request accepted this cycle (counts only when imem_req=1)
imem_rvalid  input  1  response valid; responses return in request order
imem_rdata  input  32  response data

Behaviour:
- Async reset (rst_n=0): state=IDLE; FIFO empty; outstanding=0; drop_cnt=0; fetch_addr=0; lookup_q=0; outputs imem_req=0, imem_addr=0, inst_ready=0, instruction=NOP_WORD. Reset asserted mid-operation clears everything immediately; late rvalids arriving after release are ignored (outstanding=0).
- lookup_q <= inst_addr[31:2] on every clock edge (no enable).
- Expected head tag E:
  - FIFO non-empty: E = head.addr.
  - FIFO empty: E = fetch_addr - outstanding (in words).
- inst_ready = (state==STREAM) && FIFO non-empty && head.addr==lookup_q.
- instruction = head.data when inst_ready, else NOP_WORD. Both outputs are purely registered-derived; there is no combinational path from inst_addr.
- Pop: the head is removed at the clock edge where inst_ready=1 and inst_addr[31:2] != lookup_q, i.e. the core has advanced. While the core stalls (same address), the head is held.
- States:
  - IDLE: one cycle only. fetch_addr <= inst_addr[31:2]; -> STREAM.
  - STREAM:
    - Issue: imem_req = (outstanding+occupancy < DEPTH) && (outstanding < MAX_OUTSTANDING); imem_addr = {fetch_addr,2'b00}.
    - On req&&gnt: fetch_addr += 1 word (wraps mod 2^30); outstanding++.
    - On rvalid: outstanding--; {fetch tag of oldest, rdata} pushed to FIFO. A push is never blocked, because issue accounting reserves the slot.
    - Miss = (state==STREAM) && (lookup_q != E).
    - On miss: FIFO flushed, fetch_addr <= lookup_q, imem_req forced 0 that cycle.
      - If outstanding_next==0: stay in STREAM.
      - Else: drop_cnt <= outstanding_next; -> DRAIN.
      - An rvalid in the miss cycle belongs to the stale stream and is discarded.
  - DRAIN:
    - imem_req=0; inst_ready=0.
    - Each rvalid decrements both drop_cnt and outstanding; data is discarded.
    - fetch_addr <= lookup_q every cycle, so a second redirect during the drain is followed.
    - -> STREAM when drop_cnt reaches 0 (on the rvalid edge).
- Simultaneous gnt and rvalid: outstanding unchanged, fetch_addr advances, push occurs.
- imem_req may deassert without a grant (on miss or DRAIN). An ungranted request has no effect.
- Timing with gnt=1 combinationally and rvalid the next cycle:
  - First inst_ready comes 3 cycles after the first post-reset edge.
  - Thereafter sustained 1 instruction/cycle.
  - Taken-branch penalty: 3 cycles with 0 outstanding; +1 per dropped response.
- Occupancy + outstanding <= DEPTH always (a verification assertion); outstanding <= MAX_OUTSTANDING always.

Test Plan:
- Cold start: release reset, inst_addr=0x1000 held, memory gnt=1, rvalid 1 cycle later, rdata=addr^0xA5A5_0000 -> imem_addr 0x1000,0x1004,... issued; inst_ready=1 on 3rd cycle with instruction=0xA5A5_1000.
- Streaming: core advances inst_addr by 4 each ready cycle, 0x1000..0x1040 -> inst_ready stays 1 every cycle after priming; instructions appear in order with no duplicates; imem_req never violates DEPTH/MAX_OUTSTANDING.
- Stall hold: inst_addr held at 0x1008 for 5 cycles -> inst_ready=1 and instruction=word(0x1008) all 5 cycles; no pop; prefetch stops once occupancy+outstanding=4.
- Redirect with in-flight drop: 2 requests outstanding, inst_addr jumps to 0x2000 -> FSM enters DRAIN, both stale responses discarded, next request imem_addr=0x2000, first ready word=word(0x2000); no 0x10xx word delivered after the jump.
- Backpressure/odd timing: gnt random 50%, rvalid latency 1-3 cycles, simultaneous gnt+rvalid and a miss in the same cycle as an rvalid -> delivered stream matches the golden PC trace; outstanding never exceeds 2.
- Reset mid-DRAIN: assert rst_n=0 with drop_cnt=2 -> outputs immediately imem_req=0, inst_ready=0, instruction=0x0000_0013; after release, a restart from the new inst_addr behaves as in cold start, and late stale rvalids are ignored.
